// File: rtl/calc_display_ctrl.sv
// calc_display_ctrl: captures a print burst of 8 digits and scans them onto 8 seven-segment displays.
// Ports: clock, reset (sync, active-high); status/data/pos from the calculator core;
// an (active-low digit enables, an[0] = least significant digit), seg ({g..a}, active-low);
// busy/err are registered decodes of status. Define LZ_BLANK_EN to blank leading zeros.
module calc_display_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W = 17
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] status,
  input  logic [3:0] data,
  input  logic [3:0] pos,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       busy,
  output logic       err
);
  typedef enum logic [1:0] {IDLE, CAPTURE, COMMIT} state_t;
  state_t state, state_nx;
  logic [3:0] shadow [8];
  logic [3:0] visible [8];
  logic [CNT_W-1:0] cnt;
  logic [2:0] idx;
  logic wrap, blank, pos_ok;
  logic [6:0] glyph;
  assign wrap = cnt == CNT_W'(REFRESH_DIV - 1);
  assign pos_ok = pos >= 4'd1 && pos <= 4'd8;
  always_comb begin
    state_nx = IDLE;
    if (state == IDLE) state_nx = status == 2'b11 ? CAPTURE : IDLE;
    if (state == CAPTURE) state_nx = status == 2'b10 ? COMMIT : status == 2'b11 ? CAPTURE : IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= '0;
        visible[i] <= '0;
      end
    end else begin
      state <= state_nx;
      if (state == IDLE && status == 2'b11)
        for (int i = 0; i < 8; i++) shadow[i] <= '0;
      if (state == CAPTURE && status == 2'b11 && pos_ok) shadow[3'(pos - 4'd1)] <= data;
      if (state == COMMIT)
        for (int i = 0; i < 8; i++) visible[i] <= shadow[i];
    end
  end
  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: dec = 7'b1000000;
      4'd1: dec = 7'b1111001;
      4'd2: dec = 7'b0100100;
      4'd3: dec = 7'b0110000;
      4'd4: dec = 7'b0011001;
      4'd5: dec = 7'b0010010;
      4'd6: dec = 7'b0000010;
      4'd7: dec = 7'b1111000;
      4'd8: dec = 7'b0000000;
      4'd9: dec = 7'b0010000;
      default: dec = 7'b1111111;
    endcase
  endfunction
`ifdef LZ_BLANK_EN
  // lead[i]: digit i and everything above it are zero
  logic [8:0] lead;
  always_comb begin
    lead = '0;
    lead[8] = 1'b1;
    for (int i = 7; i >= 0; i--) lead[i] = lead[i+1] && visible[i] == 4'd0;
    blank = idx != 3'd0 && lead[idx];
  end
`else
  assign blank = 1'b0;
`endif
  // error text "Erro" occupies indices 3..0; 4..7 stay dark
  assign glyph = status == 2'b00 ? (idx == 3'd3 ? 7'b0000110 : idx == 3'd0 ? 7'b0100011 :
                                    idx[2] ? 7'b1111111 : 7'b0101111)
               : blank ? 7'b1111111 : dec(visible[idx]);
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
      an <= 8'hFF;
      seg <= 7'h7F;
      busy <= 1'b0;
      err <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + CNT_W'(1);
      idx <= idx + 3'(wrap);
      an <= ~(8'd1 << idx);
      seg <= glyph;
      busy <= status == 2'b01;
      err <= status == 2'b00;
    end
  end
endmodule

// File: tb/tb_calc_display_ctrl.sv
// tb_calc_display_ctrl: randomized bench for calc_display_ctrl against a behavioural model.
module tb_calc_display_ctrl;
  localparam int DIV = 4;
  localparam logic [6:0] DIG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  logic clock, reset;
  logic [1:0] status;
  logic [3:0] data, pos;
  logic [7:0] an;
  logic [6:0] seg;
  logic busy, err;
  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  logic [3:0] sh [8];
  logic [3:0] vis [8];
  bit cap = 0, due = 0;
  logic [7:0] e_an;
  logic [6:0] e_seg;
  logic e_busy, e_err;
  calc_display_ctrl #(.REFRESH_DIV(DIV), .CNT_W(2)) dut (
    .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
    .an(an), .seg(seg), .busy(busy), .err(err)
  );
  initial clock = 0;
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
  endtask
  function automatic logic [6:0] exp_glyph(input int i, input logic [1:0] s);
    if (s == 2'b00) begin
      if (i == 3) return 7'b0000110;
      if (i == 1 || i == 2) return 7'b0101111;
      if (i == 0) return 7'b0100011;
      return 7'h7F;
    end
    if (vis[i] > 9) return 7'h7F;
`ifdef LZ_BLANK_EN
    if (i > 0) begin
      bit z = 1;
      for (int k = i; k < 8; k++) if (vis[k] != 0) z = 0;
      if (z) return 7'h7F;
    end
`endif
    return DIG[vis[i]];
  endfunction
  task automatic step(input logic r, input logic [1:0] s, input logic [3:0] d, input logic [3:0] p);
    reset = r; status = s; data = d; pos = p;
    @(posedge clock);
    if (r) begin
      for (int i = 0; i < 8; i++) begin sh[i] = 0; vis[i] = 0; end
      cap = 0; due = 0; cyc = 0;
      e_an = 8'hFF; e_seg = 7'h7F; e_busy = 0; e_err = 0;
    end else begin
      int ix = (cyc / DIV) % 8;
      e_an = ~(8'd1 << ix);
      e_seg = exp_glyph(ix, s);
      e_busy = s == 2'b01;
      e_err = s == 2'b00;
      cyc++;
      if (due) begin
        for (int i = 0; i < 8; i++) vis[i] = sh[i];
        due = 0;
      end else if (cap) begin
        if (s == 2'b11 && p >= 1 && p <= 8) sh[p-1] = d;
        if (s == 2'b10) begin cap = 0; due = 1; end
        else if (s != 2'b11) cap = 0;
      end else if (s == 2'b11) begin
        cap = 1;
        for (int i = 0; i < 8; i++) sh[i] = 0;
      end
    end
    #1;
    chk("an", 32'(an), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("err", 32'(err), 32'(e_err));
  endtask
  task automatic idle(input int n, input logic [1:0] s);
    for (int i = 0; i < n; i++) step(0, s, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
  endtask
  // one print burst: entry cycle, positions 1..8 (optionally with stray positions), then the end status
  task automatic burst(input logic [3:0] dg [8], input logic [1:0] fin, input bit stray);
    step(0, 2'b11, 4'd0, 4'd0);
    for (int p = 1; p <= 8; p++) begin
      if (stray && $urandom_range(0, 3) == 0)
        step(0, 2'b11, 4'($urandom_range(0, 15)), $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(9, 15)));
      step(0, 2'b11, dg[p-1], 4'(p));
    end
    step(0, fin, 4'd0, 4'd0);
  endtask
  initial begin
    logic [3:0] dg [8];
    repeat (3) step(1, 2'b10, 4'd0, 4'd0);
    idle(40, 2'b10);
    dg = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    burst(dg, 2'b10, 0);
    idle(40, 2'b10);
    step(0, 2'b11, 4'd0, 4'd0);
    for (int p = 1; p <= 3; p++) step(0, 2'b11, 4'(p + 4), 4'(p));
    idle(40, 2'b00);
    idle(10, 2'b01);
    dg = '{4'd9, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    burst(dg, 2'b10, 0);
    idle(40, 2'b10);
    step(0, 2'b11, 4'd0, 4'd0);
    for (int p = 1; p <= 4; p++) step(0, 2'b11, 4'd7, 4'(p));
    step(1, 2'b11, 4'd7, 4'd5);
    idle(12, 2'b10);
    for (int it = 0; it < 80; it++) begin
      int top = $urandom_range(0, 8);
      int e = $urandom_range(0, 9);
      for (int i = 0; i < 8; i++)
        dg[i] = i < top ? ($urandom_range(0, 7) == 0 ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9))) : 4'd0;
      burst(dg, e < 7 ? 2'b10 : e < 9 ? 2'b00 : 2'b01, 1);
      case ($urandom_range(0, 4))
        0: ;
        1: idle($urandom_range(1, 40), 2'b10);
        2: idle($urandom_range(1, 12), 2'b01);
        3: idle($urandom_range(1, 12), 2'b00);
        default: for (int i = 0; i < 10; i++)
          step($urandom_range(0, 15) == 0, 2'($urandom), 4'($urandom), 4'($urandom));
      endcase
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/calc_display_ctrl.md
Name: calc_display_ctrl

Overview:
- Downstream consumer of the calculator core's `status`/`data`/`pos` print stream.
- Captures the 8 decimal digits streamed during a print burst into a shadow buffer.
- Commits them atomically to a visible buffer when the burst completes.
- Time-multiplexes the visible buffer onto 8 common-anode seven-segment displays. Shows "Erro" on error status and flags busy.

Parameters:
- REFRESH_DIV, 100000: clock cycles each digit stays enabled before the scan advances (min 2).
- CNT_W, 17: width of the refresh counter; must hold REFRESH_DIV-1.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- status  input  2  core status: 00 error, 01 busy, 10 ready, 11 printing
- data  input  4  digit value from core, 0-9 valid
- pos  input  4  core print position counter
- an  output  8  digit enables, active-low; an[0] = least significant digit
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- busy  output  1  high while status==01
- err  output  1  high while status==00

Behaviour:
- One clock, `clock`. `reset` is synchronous and active-high.
- Reset values:
  - an=8'hFF, seg=7'h7F, busy=0, err=0.
  - Shadow and visible buffers all 0.
  - Refresh counter 0, scan index 0, capture FSM in IDLE.
- Capture FSM (IDLE, CAPTURE, COMMIT):
  - IDLE: status==11 -> CAPTURE and clear shadow to 0 in that same cycle.
  - CAPTURE, write rule: every cycle with status==11 and 1<=pos<=8, write shadow[pos-1] <= data. This compensates for the core updating data and pos in the same edge. pos==0 or pos>8: no write.
  - CAPTURE, exit: status==10 -> COMMIT. status 00 or 01 -> IDLE, shadow discarded, visible unchanged.
  - COMMIT: visible <= shadow (all 8 digits in one cycle), then -> IDLE.
  - COMMIT, re-entry: if status==11 during COMMIT, the next cycle enters CAPTURE via IDLE; at most one cycle of the new burst is lost.
- Visible buffer changes only in COMMIT. Reset mid-burst: buffers cleared, FSM IDLE.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, scan index increments mod 8 (7 -> 0).
  - an and seg are registered: one cycle after an index change, an shows one-hot-low at the index and seg shows its glyph.
- Glyph select, priority order:
  1. err path (status==00): index 3..0 show E,r,r,o; indices 7..4 blank.
  2. Otherwise: visible digit at index, with leading-zero blanking (see Optional Feature).
- Visible digit values 10-15: blank glyph.
- Segment codes, active-low {g..a}:
  - Digits: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Letters: E=0000110, r=0101111, o=0100011.
  - blank=1111111.
- busy and err are registered decodes of status, 1-cycle latency.
- Status 01 does not alter the display; the last committed value stays shown.

Optional Feature:
- Macro: LZ_BLANK_EN.
- Defined: a visible digit at index i is blanked if it and every digit above it are 0. Index 0 is never blanked, so value 0 shows a single "0".
- Undefined: all 8 digits always shown, including leading zeros.

Test Plan:
All scenarios use REFRESH_DIV=4 unless stated.
- Reset held 3 cycles -> an=FF, seg=7F, busy=0, err=0; after release the first an is FE with seg=1000000 (digit 0 = "0").
- Burst status=11, pos 1..8 with data 3,2,1,0,0,0,0,0, then status=10 -> after COMMIT, scan shows indices 0,1,2 = 3,2,1. Indices 3..7 blank with LZ_BLANK_EN, "0" without.
- Burst aborted: status=11 for pos 1..3, then status=00 -> visible unchanged; err=1 the next cycle; indices 3..0 show 0000110, 0101111, 0101111, 0100011; indices 7..4 blank.
- Scan wrap: run 32+ cycles -> an sequence FE, FD, FB, F7, EF, DF, BF, 7F, FE, each held exactly 4 cycles.
- Busy then commit: status=01 for 10 cycles -> busy=1, display holds previous value; then burst of 9,9,0..0 and status=10 -> shows 99.
- Reset asserted mid-CAPTURE at pos=5 -> next cycle FSM IDLE, visible all 0, an=FF.
